// File: rtl/imm_ext_pkg.sv
// ---------------------------------------------------------------------------
// imm_ext_pkg
//
// Shared types for the immediate-extension stage and for any other datapath
// block (e.g. branch-target logic) that reuses the extension mux.
//
// Contents:
//   imm_mode_e   - 2-bit extension mode: IMM_ZERO, IMM_SIGN, IMM_SIGN_SHL2,
//                  IMM_UPPER (encodings match the decode field in_mode).
//   skid_state_e - occupancy of the optional two-entry skid buffer:
//                  EMPTY, ONE (main valid), TWO (main + skid valid).
//   to_imm_mode  - converts a raw 2-bit decode field into imm_mode_e.
// ---------------------------------------------------------------------------
package imm_ext_pkg;

    localparam int IMM_MODE_W = 2;

    typedef enum logic [IMM_MODE_W-1:0] {
        IMM_ZERO      = 2'b00,
        IMM_SIGN      = 2'b01,
        IMM_SIGN_SHL2 = 2'b10,
        IMM_UPPER     = 2'b11
    } imm_mode_e;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } skid_state_e;

    // All four encodings are legal modes, so a plain cast is lossless.
    function automatic imm_mode_e to_imm_mode(input logic [IMM_MODE_W-1:0] raw);
        return imm_mode_e'(raw);
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// ---------------------------------------------------------------------------
// imm_ext_core
//
// Purely combinational immediate-extension mux. Widens an IN_W-bit
// immediate to OUT_W bits according to the selected mode. Kept separate
// from the pipeline register so branch-target logic can reuse it.
//
// Parameters:
//   IN_W  - immediate field width, 2 <= IN_W < OUT_W
//   OUT_W - extended datapath width
//
// Ports:
//   in_imm    in   IN_W   raw immediate field
//   in_mode   in   2      00 ZERO, 01 SIGN, 10 SIGN_SHL2, 11 UPPER
//   ext_value out  OUT_W  extended immediate
// ---------------------------------------------------------------------------
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 6,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]       in_imm,
    input  logic [IMM_MODE_W-1:0] in_mode,
    output logic [OUT_W-1:0]      ext_value
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] sign_shl2;
    logic [OUT_W-1:0] upper_ext;
    imm_mode_e        mode;

    assign mode      = to_imm_mode(in_mode);
    assign zero_ext  = {{PAD_W{1'b0}}, in_imm};
    assign sign_ext  = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
    // Branch offsets are word counts: the two top bits of the sign-extended
    // value fall off the end and the byte offset bits become zero.
    assign sign_shl2 = {sign_ext[OUT_W-3:0], 2'b00};
    // lui-style placement: immediate occupies the most significant bits.
    assign upper_ext = {in_imm, {PAD_W{1'b0}}};

    always_comb begin
        ext_value = zero_ext;
        case (mode)
            IMM_ZERO:      ext_value = zero_ext;
            IMM_SIGN:      ext_value = sign_ext;
            IMM_SIGN_SHL2: ext_value = sign_shl2;
            IMM_UPPER:     ext_value = upper_ext;
            default:       ext_value = zero_ext;
        endcase
    end

endmodule

// File: rtl/imm_extend_stage.sv
// ---------------------------------------------------------------------------
// imm_extend_stage
//
// Pipelined immediate-extension stage between decode and the ALU operand
// mux. The extension is computed combinationally from the input and
// captured, together with a sideband tag, into a valid/ready output
// register so decode and execute can stall independently. Order is
// preserved and nothing is dropped or duplicated.
//
// Configuration macro: IMM_EXT_SKID_EN
//   defined   - two-entry skid buffer (main + skid register), in_ready is a
//               flop equal to (state != TWO); no combinational path from
//               out_ready to in_ready.
//   undefined - single output register, in_ready = !out_valid || out_ready.
//
// Parameters:
//   IN_W  (6)  - immediate width, 2 <= IN_W < OUT_W
//   OUT_W (32) - extended width
//   TAG_W (5)  - sideband width, >= 1
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      synchronous active-low reset
//   in_valid  in   1      upstream has an immediate
//   in_ready  out  1      stage accepts this cycle
//   in_imm    in   IN_W   raw immediate field
//   in_mode   in   2      extension mode
//   in_tag    in   TAG_W  sideband
//   out_valid out  1      result available
//   out_ready in   1      downstream accepts
//   out_data  out  OUT_W  extended immediate
//   out_tag   out  TAG_W  sideband matching out_data
// ---------------------------------------------------------------------------
module imm_extend_stage
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 6,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_imm,
    input  logic [IMM_MODE_W-1:0] in_mode,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic [TAG_W-1:0]      out_tag
);

    logic [OUT_W-1:0] ext_value;
    logic             accept;
    logic             pop;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .ext_value (ext_value)
    );

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

`ifdef IMM_EXT_SKID_EN

    skid_state_e      state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [OUT_W-1:0] main_data_q, main_data_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic [OUT_W-1:0] skid_data_q, skid_data_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

    // Occupancy FSM plus data movement. The main register always holds the
    // oldest entry; the skid register only catches an entry that arrives
    // while main is stalled, and drains into main on the next pop.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_tag_d  = main_tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d     = ONE;
                    main_data_d = ext_value;
                    main_tag_d  = in_tag;
                end
            end
            ONE: begin
                case ({accept, pop})
                    2'b10: begin
                        state_d     = TWO;
                        skid_data_d = ext_value;
                        skid_tag_d  = in_tag;
                    end
                    2'b01: begin
                        state_d = EMPTY;
                    end
                    2'b11: begin
                        state_d     = ONE;
                        main_data_d = ext_value;
                        main_tag_d  = in_tag;
                    end
                    default: begin
                        state_d = ONE;
                    end
                endcase
            end
            TWO: begin
                if (pop) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_tag_d  = skid_tag_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Registered ready: looks ahead at the next occupancy so upstream
        // never sees a combinational dependency on out_ready.
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b0;
            main_data_q <= '0;
            main_tag_q  <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_data_q <= main_data_d;
            main_tag_q  <= main_tag_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_tag   = main_tag_q;

`else

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    // Single register: a new entry may load in the same cycle the old one
    // is popped, which gives full throughput without a skid entry.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = ext_value;
            out_tag_d   = in_tag;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end

    // Ready is forced low while reset is held so nothing appears accepted.
    assign in_ready  = rst_n && (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

`endif

endmodule

// File: tb/tb_imm_extend_stage.sv
// ---------------------------------------------------------------------------
// tb_imm_extend_stage
//
// Self-checking bench for imm_extend_stage. Expected results are pushed into
// a scoreboard queue on every input transfer; a separate monitor pops and
// compares on every output transfer. A second instance with IN_W = 16
// covers the wide-immediate cases. Build with or without IMM_EXT_SKID_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_imm_extend_stage;

    localparam int IN_W  = 6;
    localparam int OUT_W = 32;
    localparam int TAG_W = 5;

`ifdef IMM_EXT_SKID_EN
    localparam int STALL_ACCEPTS = 2;
`else
    localparam int STALL_ACCEPTS = 1;
`endif

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [TAG_W-1:0] tag;
    } sb_entry_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    logic             in16_valid;
    logic             in16_ready;
    logic [15:0]      in16_imm;
    logic [1:0]       in16_mode;
    logic [TAG_W-1:0] in16_tag;
    logic             out16_valid;
    logic             out16_ready;
    logic [OUT_W-1:0] out16_data;
    logic [TAG_W-1:0] out16_tag;

    sb_entry_t sb[$];
    int        n_cmp;
    int        n_err;
    int        n_push;
    int        n_pop;
    int        cyc;

    imm_extend_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    imm_extend_stage #(.IN_W(16), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in16_valid),
        .in_ready  (in16_ready),
        .in_imm    (in16_imm),
        .in_mode   (in16_mode),
        .in_tag    (in16_tag),
        .out_valid (out16_valid),
        .out_ready (out16_ready),
        .out_data  (out16_data),
        .out_tag   (out16_tag)
    );

    // Free-running clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Reference model: integer arithmetic on the value of the immediate,
    // reduced modulo 2**OUT_W.
    function automatic logic [OUT_W-1:0] refExtend(input logic [IN_W-1:0] imm,
                                                    input logic [1:0] mode);
        longint u;
        longint s;
        longint r;
        longint one;
        one = 1;
        u = longint'(imm);
        s = (u >= (one << (IN_W - 1))) ? u - (one << IN_W) : u;
        case (mode)
            2'd0:    r = u;
            2'd1:    r = s;
            2'd2:    r = s * 4;
            default: r = u * (one << (OUT_W - IN_W));
        endcase
        return r[OUT_W-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_cmp = n_cmp + 1;
        if (actual !== expected) begin
            n_err = n_err + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Monitor: transfers happen at the next rising edge, so they are judged
    // at the falling edge where every handshake signal is settled. Pop is
    // handled before push so a same-cycle accept never satisfies its own pop.
    always @(negedge clk) begin
        sb_entry_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_output", 64'(out_data), 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    n_pop = n_pop + 1;
                    checkOutput("sb_data", 64'(out_data), 64'(e.data));
                    checkOutput("sb_tag", 64'(out_tag), 64'(e.tag));
                end
            end
            if (in_valid && in_ready) begin
                e.data = refExtend(in_imm, in_mode);
                e.tag  = in_tag;
                sb.push_back(e);
                n_push = n_push + 1;
            end
        end
    end

    // Presents one input and holds it until accepted; returns just after
    // the accepting edge with in_valid still high.
    task automatic applyStimulus(input logic [IN_W-1:0] imm, input logic [1:0] mode,
                                 input logic [TAG_W-1:0] tag);
        bit took;
        took     = 1'b0;
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) break;
        end
        if (!took) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        checkOutput("drain_empty", 64'(sb.size()), 64'd0);
        checkOutput("drain_out_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic apply16(input logic [15:0] imm, input logic [1:0] mode,
                           input logic [TAG_W-1:0] tag, input logic [OUT_W-1:0] expected,
                           input string name);
        bit took;
        took        = 1'b0;
        in16_valid  = 1'b1;
        in16_imm    = imm;
        in16_mode   = mode;
        in16_tag    = tag;
        out16_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            took = in16_ready;
            @(posedge clk);
            #1;
            if (took) break;
        end
        in16_valid = 1'b0;
        checkOutput({name, "_valid"}, 64'(out16_valid), 64'd1);
        checkOutput({name, "_data"}, 64'(out16_data), 64'(expected));
        checkOutput({name, "_tag"}, 64'(out16_tag), 64'(tag));
    endtask

    initial begin
        int        acc;
        int        c0;
        int        accepted;
        int        guard;
        bit        pend;
        bit        took;
        logic [OUT_W-1:0] first_exp;

        n_cmp = 0; n_err = 0; n_push = 0; n_pop = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
        in16_valid = 1'b0; in16_imm = '0; in16_mode = '0; in16_tag = '0; out16_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_in_ready", 64'(in_ready), 64'd1);

        // Directed modes, one cycle latency.
        applyStimulus(6'b100101, 2'b00, 5'd1);
        in_valid = 1'b0;
        checkOutput("zero_valid", 64'(out_valid), 64'd1);
        checkOutput("zero_data", 64'(out_data), 64'h0000_0025);
        checkOutput("zero_tag", 64'(out_tag), 64'd1);
        applyStimulus(6'b100000, 2'b01, 5'd2);
        in_valid = 1'b0;
        checkOutput("sign_valid", 64'(out_valid), 64'd1);
        checkOutput("sign_data", 64'(out_data), 64'hFFFF_FFE0);
        checkOutput("sign_tag", 64'(out_tag), 64'd2);
        applyStimulus(6'b111111, 2'b10, 5'd3);
        in_valid = 1'b0;
        checkOutput("shl2_valid", 64'(out_valid), 64'd1);
        checkOutput("shl2_data", 64'(out_data), 64'hFFFF_FFFC);
        checkOutput("shl2_tag", 64'(out_tag), 64'd3);
        applyStimulus(6'b000011, 2'b11, 5'd4);
        in_valid = 1'b0;
        checkOutput("upper_valid", 64'(out_valid), 64'd1);
        checkOutput("upper_data", 64'(out_data), 64'h0C00_0000);
        checkOutput("upper_tag", 64'(out_tag), 64'd4);
        drain();

        // Back-to-back: eight inputs in eight cycles, output valid each cycle.
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(IN_W'($urandom), 2'($urandom), TAG_W'(i + 8));
            checkOutput("b2b_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        checkOutput("b2b_cycles", 64'(cyc - c0), 64'd8);
        drain();

        // Stall: out_ready low for four cycles with in_valid held.
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1; in_imm = IN_W'($urandom); in_mode = 2'($urandom); in_tag = 5'd20;
        first_exp = refExtend(in_imm, in_mode);
        repeat (4) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                acc = acc + 1;
                in_imm = IN_W'($urandom); in_mode = 2'($urandom); in_tag = TAG_W'(20 + acc);
            end
        end
        in_valid = 1'b0;
        checkOutput("stall_accepts", 64'(acc), 64'(STALL_ACCEPTS));
        checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
        checkOutput("stall_data_stable", 64'(out_data), 64'(first_exp));
        checkOutput("stall_tag_stable", 64'(out_tag), 64'd20);
        drain();

        // Random handshake toggling for 1000 input transfers.
        accepted = 0; guard = 0; pend = 1'b0;
        while (accepted < 1000 && guard < 20000) begin
            if (!pend) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_imm   = IN_W'($urandom);
                    in_mode  = 2'($urandom);
                    in_tag   = TAG_W'($urandom);
                    pend     = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                pend = 1'b0;
                accepted = accepted + 1;
            end
            guard = guard + 1;
        end
        checkOutput("random_accepted", 64'(accepted), 64'd1000);
        drain();
        checkOutput("push_pop_balance", 64'(n_pop), 64'(n_push));

        // Reset with the buffer full.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(IN_W'($urandom), 2'($urandom), TAG_W'(i));
            if (!in_ready) break;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_out_data", 64'(out_data), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_release_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_release_out_valid", 64'(out_valid), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("midrst_no_stale", 64'(out_valid), 64'd0);

        // Wide immediate instance.
        apply16(16'h8000, 2'b01, 5'd9, 32'hFFFF_8000, "w16_sign");
        apply16(16'h1234, 2'b11, 5'd10, 32'h1234_0000, "w16_upper");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
